// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with valid/ready handshake and optional skid entry.
// Carries a feedback side-band register and a saturating back-pressure counter.
module pipe_stage_skid #(
  parameter int                    PAYLOAD_W = 64,
  parameter logic [PAYLOAD_W-1:0]  NOP_VAL   = '0,
  parameter int                    FB_W      = 1,
  parameter bit                    SKID_EN   = 1'b1,
  parameter int                    CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_data,
  input  logic [FB_W-1:0]      in_fb,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_data,
  output logic [FB_W-1:0]      fb_q,
  output logic [1:0]           occupancy,
  output logic [CNT_W-1:0]     stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic                 main_valid;
  logic [PAYLOAD_W-1:0] main_data;
  logic                 skid_valid;
  logic [PAYLOAD_W-1:0] skid_data;
  logic                 acc;
  logic                 take;
  logic                 skid_load;

  assign acc       = in_valid & in_ready;
  assign take      = main_valid & out_ready;
  assign skid_load = acc & main_valid & ~take;

  assign out_valid = main_valid;
  assign out_data  = main_valid ? main_data : NOP_VAL;
  assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

  generate
    if (SKID_EN) begin : g_skid
      assign in_ready = ~skid_valid;

      always_ff @(posedge clk) begin
        if (rst) begin
          skid_valid <= 1'b0;
          skid_data  <= NOP_VAL;
        end else if (flush) begin
          skid_valid <= 1'b0;
        end else if (skid_valid & take) begin
          skid_valid <= 1'b0;
        end else if (skid_load) begin
          skid_valid <= 1'b1;
          skid_data  <= in_data;
        end
      end

      // skid only ever fills behind a held main entry
      a_order: assert property (
        @(posedge clk) disable iff (rst)
        skid_valid |-> main_valid
      );
    end else begin : g_noskid
      assign in_ready   = ~main_valid | out_ready;
      assign skid_valid = 1'b0;
      assign skid_data  = NOP_VAL;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid <= 1'b0;
      main_data  <= NOP_VAL;
    end else if (flush) begin
      main_valid <= 1'b0;
      main_data  <= NOP_VAL;
    end else if (skid_valid & take) begin
      main_data  <= skid_data;
    end else if (acc & (~main_valid | take)) begin
      main_valid <= 1'b1;
      main_data  <= in_data;
    end else if (take) begin
      main_valid <= 1'b0;
      main_data  <= NOP_VAL;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fb_q <= '0;
    end else if (flush) begin
      fb_q <= '0;
    end else if (acc) begin
      fb_q <= in_fb;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (main_valid & ~out_ready & (stall_cnt != CNT_MAX)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: skid, saturating-counter
// and single-entry variants driven from shared stimulus.
module tb_pipe_stage_skid;

  localparam int PW = 16;
  localparam logic [PW-1:0] NOP = 16'h0013;

  logic clk = 1'b0;
  logic rst, flush, in_valid, out_ready;
  logic [PW-1:0] in_data;
  logic [0:0] in_fb;

  logic          a_in_ready, a_out_valid;
  logic [PW-1:0] a_out_data;
  logic [0:0]    a_fb_q;
  logic [1:0]    a_occ;
  logic [15:0]   a_stall;

  logic          b_in_ready, b_out_valid;
  logic [PW-1:0] b_out_data;
  logic [0:0]    b_fb_q;
  logic [1:0]    b_occ;
  logic [3:0]    b_stall;

  logic          c_in_ready, c_out_valid;
  logic [PW-1:0] c_out_data;
  logic [0:0]    c_fb_q;
  logic [1:0]    c_occ;
  logic [15:0]   c_stall;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_stage_skid #(
    .PAYLOAD_W(PW), .NOP_VAL(NOP), .FB_W(1),
    .SKID_EN(1'b1), .CNT_W(16)
  ) u_a (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(a_in_ready),
    .in_data(in_data), .in_fb(in_fb),
    .out_valid(a_out_valid), .out_ready(out_ready),
    .out_data(a_out_data), .fb_q(a_fb_q),
    .occupancy(a_occ), .stall_cnt(a_stall)
  );

  pipe_stage_skid #(
    .PAYLOAD_W(PW), .NOP_VAL(NOP), .FB_W(1),
    .SKID_EN(1'b1), .CNT_W(4)
  ) u_b (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(b_in_ready),
    .in_data(in_data), .in_fb(in_fb),
    .out_valid(b_out_valid), .out_ready(out_ready),
    .out_data(b_out_data), .fb_q(b_fb_q),
    .occupancy(b_occ), .stall_cnt(b_stall)
  );

  pipe_stage_skid #(
    .PAYLOAD_W(PW), .NOP_VAL(NOP), .FB_W(1),
    .SKID_EN(1'b0), .CNT_W(16)
  ) u_c (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(c_in_ready),
    .in_data(in_data), .in_fb(in_fb),
    .out_valid(c_out_valid), .out_ready(out_ready),
    .out_data(c_out_data), .fb_q(c_fb_q),
    .occupancy(c_occ), .stall_cnt(c_stall)
  );

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset;
    rst = 1'b1;
    flush = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    in_fb = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    do_reset();
    chk("rst_out_valid", 64'(a_out_valid), 64'd0);
    chk("rst_out_data", 64'(a_out_data), 64'(NOP));
    chk("rst_occ", 64'(a_occ), 64'd0);
    chk("rst_fb_q", 64'(a_fb_q), 64'd0);
    chk("rst_stall", 64'(a_stall), 64'd0);
    chk("rst_in_ready", 64'(a_in_ready), 64'd1);

    // stream 1..8 back-to-back
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_data = PW'(i);
      tick();
      chk("stream_valid", 64'(a_out_valid), 64'd1);
      chk("stream_data", 64'(a_out_data), 64'(i));
      chk("stream_occ", 64'(a_occ), 64'd1);
    end
    in_valid = 1'b0;
    tick();
    chk("stream_drain_valid", 64'(a_out_valid), 64'd0);
    chk("stream_drain_data", 64'(a_out_data), 64'(NOP));
    chk("stream_drain_occ", 64'(a_occ), 64'd0);

    // back-pressure: 0xA then 0xB while out_ready=0
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 16'h000A;
    tick();
    chk("bp_occ1", 64'(a_occ), 64'd1);
    in_data = 16'h000B;
    tick();
    chk("bp_occ2", 64'(a_occ), 64'd2);
    chk("bp_in_ready", 64'(a_in_ready), 64'd0);
    in_valid = 1'b0;
    in_data = 16'h5555;
    tick();
    chk("bp_hold_data", 64'(a_out_data), 64'hA);
    tick();
    chk("bp_stall", 64'(a_stall), 64'd3);
    chk("bp_occ_hold", 64'(a_occ), 64'd2);
    chk("bp_hold_data2", 64'(a_out_data), 64'hA);
    out_ready = 1'b1;
    tick();
    chk("bp_second", 64'(a_out_data), 64'hB);
    chk("bp_occ_after", 64'(a_occ), 64'd1);
    chk("bp_in_ready_after", 64'(a_in_ready), 64'd1);
    tick();
    chk("bp_empty", 64'(a_out_valid), 64'd0);
    chk("bp_stall_kept", 64'(a_stall), 64'd3);

    // flush with skid full and 0xC offered
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_fb = 1'b1;
    in_data = 16'h000A;
    tick();
    in_data = 16'h000B;
    tick();
    chk("fl_occ_pre", 64'(a_occ), 64'd2);
    chk("fl_fb_pre", 64'(a_fb_q), 64'd1);
    flush = 1'b1;
    in_data = 16'h000C;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl_valid", 64'(a_out_valid), 64'd0);
    chk("fl_data", 64'(a_out_data), 64'(NOP));
    chk("fl_occ", 64'(a_occ), 64'd0);
    chk("fl_fb", 64'(a_fb_q), 64'd0);
    chk("fl_in_ready", 64'(a_in_ready), 64'd1);
    out_ready = 1'b1;
    tick();
    chk("fl_no_c", 64'(a_out_valid), 64'd0);

    // flush wins over an acc that in_ready allows
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_fb = 1'b0;
    in_data = 16'h000D;
    tick();
    in_fb = 1'b1;
    in_data = 16'h000E;
    flush = 1'b1;
    #1;
    chk("fl2_in_ready", 64'(a_in_ready), 64'd1);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl2_occ", 64'(a_occ), 64'd0);
    chk("fl2_fb", 64'(a_fb_q), 64'd0);
    chk("fl2_stall_kept", 64'(a_stall), 64'd6);
    out_ready = 1'b1;
    tick();
    chk("fl2_no_e", 64'(a_out_valid), 64'd0);

    // feedback captured only on accept
    in_valid = 1'b1;
    in_data = 16'h0005;
    in_fb = 1'b1;
    tick();
    chk("fb_cap", 64'(a_fb_q), 64'd1);
    chk("fb_data", 64'(a_out_data), 64'h5);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_fb = 1'(i);
      tick();
      chk("fb_hold", 64'(a_fb_q), 64'd1);
    end
    in_valid = 1'b1;
    in_data = 16'h0006;
    in_fb = 1'b0;
    tick();
    chk("fb_recap", 64'(a_fb_q), 64'd0);
    in_valid = 1'b0;
    tick();

    // saturation on the 4-bit counter
    do_reset();
    in_valid = 1'b1;
    in_data = 16'h0007;
    tick();
    in_valid = 1'b0;
    for (int k = 1; k <= 22; k++) begin
      tick();
      if (k == 10 || k >= 15) begin
        chk("sat_b", 64'(b_stall), (k > 15) ? 64'd15 : 64'(k));
      end
    end
    chk("sat_a_nowrap", 64'(a_stall), 64'd22);
    chk("sat_b_data", 64'(b_out_data), 64'h7);

    // single-entry variant
    do_reset();
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_data = 16'h0001;
    #1;
    chk("ns_ready_empty", 64'(c_in_ready), 64'd1);
    tick();
    out_ready = 1'b0;
    in_data = 16'h0002;
    #1;
    chk("ns_ready_block", 64'(c_in_ready), 64'd0);
    out_ready = 1'b1;
    #1;
    chk("ns_ready_comb", 64'(c_in_ready), 64'd1);
    for (int i = 2; i <= 5; i++) begin
      in_data = PW'(i);
      tick();
      chk("ns_data", 64'(c_out_data), 64'(i));
      chk("ns_occ", 64'(c_occ), 64'd1);
    end
    in_valid = 1'b0;
    tick();
    chk("ns_empty", 64'(c_out_data), 64'(NOP));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
